hazard_controller: RTL and testbench
====================================

# hazard_controller

Central pipeline sequencer for the five-stage MIPS core. It produces the stall/flush pair for each pipeline register (IF→DEC, DEC→EX, EX→MEM, MEM→WB) and the fetch-PC load. It owns a table of 2-bit branch predictors indexed by PC, and 32-bit performance counters. All hazard resolution (d-cache miss, i-cache miss, load-use, branch redirect) is decided here, in one place.

## Interface

- BHT_IDX_BITS, 6: log2 of predictor entries; index = pc[BHT_IDX_BITS+1:2]
- ADDR_WIDTH, 32: PC/target width

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- i_cache_valid  in  1  IF output valid (0 = i-cache miss)
- mem_is_access  in  1  MEM stage holds a load/store
- d_cache_valid  in  1  d-cache output valid
- dec_pc  in  ADDR_WIDTH  PC of DEC instruction
- dec_branch_valid / dec_is_jump  in  1/1  DEC holds branch-or-jump / jump
- dec_target  in  ADDR_WIDTH  decoded branch/jump target
- dec_uses_rs, dec_uses_rt  in  1  DEC reads rs/rt
- dec_rs_addr, dec_rt_addr  in  5  DEC source registers
- ex_mem_read, ex_uses_rw  in  1  EX is a load / EX writes rw
- ex_rw_addr  in  5  EX destination register
- ex_pc  in  ADDR_WIDTH  PC of EX instruction
- ex_branch_valid  in  1  EX holds a conditional branch (not jumps)
- ex_prediction, ex_outcome  in  1  1 = taken
- ex_target  in  ADDR_WIDTH  resolved correct next PC
- dec_prediction  out  1  prediction for DEC instruction
- dec_target_post_predict  out  ADDR_WIDTH  predicted next PC
- load_pc_we, load_pc_new_pc  out  1/ADDR_WIDTH  fetch redirect
- pc_stall  out  1  hold PC
- i2d_stall/i2d_flush, d2e_stall/d2e_flush, e2m_stall/e2m_flush, m2w_stall/m2w_flush  out  1 each  per-register controls; stall dominates flush in the register
- perf_stall_cycles, perf_branches, perf_mispredicts  out  32 each  saturating counters

## Operation

Hazard terms (combinational):
- mem_miss = mem_is_access & ~d_cache_valid
- mispredict = ex_branch_valid & (ex_prediction != ex_outcome)
- load_use = ex_mem_read & ex_uses_rw & ex_rw_addr != 0, and either (dec_uses_rs & dec_rs_addr == ex_rw_addr) or (dec_uses_rt & dec_rt_addr == ex_rw_addr)
- ic_miss = ~i_cache_valid

Prediction:
- dec_prediction = dec_is_jump | (dec_branch_valid & bht[idx(dec_pc)][1]).
- dec_target_post_predict = dec_prediction ? dec_target : dec_pc + 4. The core has no delay slot. The +4 add is modulo 2^ADDR_WIDTH.

Strict priority; only the first matching row applies. Unlisted outputs are 0.
1. mem_miss: pc_stall, i2d_stall, d2e_stall, e2m_stall = 1; m2w_flush = 1. No redirect and no BHT update.
2. mispredict: load_pc_we = 1, new_pc = ex_target; i2d_flush = d2e_flush = 1.
3. load_use: pc_stall = i2d_stall = 1; d2e_flush = 1.
4. Otherwise:
   - If dec_prediction = 1: load_pc_we = 1, new_pc = dec_target, i2d_flush = 1.
   - If ic_miss: i2d_flush = 1, and pc_stall = ~load_pc_we.

BHT update (sequential):
- Applies when ex_branch_valid & ~mem_miss, i.e. the branch leaves EX this cycle, so each branch is counted once.
- bht[idx(ex_pc)] increments on taken (saturates at 3) and decrements on not-taken (saturates at 0).
- A same-cycle DEC read of the same index returns the old value; there is no bypass.

Perf counters (sequential, each saturates at 0xFFFFFFFF):
- perf_stall_cycles increments on any cycle with mem_miss | load_use | ic_miss.
- perf_branches increments on each BHT update.
- perf_mispredicts increments on each BHT update where mispredict = 1.

## Timing

- All control outputs are combinational from the current-cycle inputs plus BHT state. Zero latency: a hazard is acted on in the cycle it appears.
- BHT and counters update on the rising clk edge and are visible the next cycle.
- Reset (rst_n = 0 at an edge):
  - All BHT entries become 2'b01 (weakly not-taken); all perf counters become 0.
  - While rst_n = 0, the outputs are forced to: every *_flush = 1, every *_stall = 0, pc_stall = 0, load_pc_we = 0.
- Reset mid-miss or mid-redirect discards all pending state. There is no stored redirect.
- Multi-cycle mem_miss: the stall is held every cycle. A mispredict waiting in EX redirects in the first cycle after d_cache_valid rises.
- A simultaneous EX mispredict and DEC taken prediction: EX wins, and the DEC instruction is flushed.
- DEC taken prediction during load_use: suppressed that cycle and issued once load_use clears.

## Test plan

- Reset, then branch at PC 0x0040_0010 in DEC → dec_prediction = 0, dec_target_post_predict = 0x0040_0014; all perf counters = 0.
- The same branch resolves taken twice in EX (0x0040_0010, ex_prediction = 0):
  - Each resolution: load_pc_we = 1, new_pc = ex_target, i2d/d2e flushed.
  - perf_mispredicts = 2.
  - The next DEC of that PC gives dec_prediction = 1 and a target redirect.
- Load to $t0 in EX while DEC reads rt = $t0 → pc_stall = i2d_stall = d2e_flush = 1 for exactly one cycle. Repeat with $zero → no stall.
- mem_miss for 5 cycles concurrent with an EX mispredict:
  - During the miss: stalls asserted, m2w_flush = 1, no redirect, perf_stall_cycles += 5.
  - Cycle 6: the redirect fires, and the BHT updates exactly once.
- DEC jump while ic_miss → load_pc_we = 1, new_pc = dec_target, pc_stall = 0, i2d_flush = 1.
- Counter saturation: 3 taken resolutions at one index keep the entry at 3; preload perf_branches at 0xFFFFFFFF → it stays 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_controller: pipeline stall/flush sequencer with 2-bit BHT and perf   |
// | counters. Revision: 1.0                                                    |
// +----------------------------------------------------------------------------+
module hazard_controller #(
  parameter int BHT_IDX_BITS = 6,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cache_valid,
  input  logic                  mem_is_access,
  input  logic                  d_cache_valid,
  input  logic [ADDR_WIDTH-1:0] dec_pc,
  input  logic                  dec_branch_valid,
  input  logic                  dec_is_jump,
  input  logic [ADDR_WIDTH-1:0] dec_target,
  input  logic                  dec_uses_rs,
  input  logic                  dec_uses_rt,
  input  logic [4:0]            dec_rs_addr,
  input  logic [4:0]            dec_rt_addr,
  input  logic                  ex_mem_read,
  input  logic                  ex_uses_rw,
  input  logic [4:0]            ex_rw_addr,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic                  ex_branch_valid,
  input  logic                  ex_prediction,
  input  logic                  ex_outcome,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  output logic                  dec_prediction,
  output logic [ADDR_WIDTH-1:0] dec_target_post_predict,
  output logic                  load_pc_we,
  output logic [ADDR_WIDTH-1:0] load_pc_new_pc,
  output logic                  pc_stall,
  output logic                  i2d_stall,
  output logic                  i2d_flush,
  output logic                  d2e_stall,
  output logic                  d2e_flush,
  output logic                  e2m_stall,
  output logic                  e2m_flush,
  output logic                  m2w_stall,
  output logic                  m2w_flush,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_branches,
  output logic [31:0]           perf_mispredicts
);

  localparam int c_BHT_ENTRIES = 1 << BHT_IDX_BITS;

  logic [1:0]              bht_q [c_BHT_ENTRIES];
  logic [31:0]             stall_cnt_q, br_cnt_q, mp_cnt_q;
  logic [BHT_IDX_BITS-1:0] w_dec_idx, w_ex_idx;
  logic                    w_mem_miss, w_mispredict, w_load_use, w_ic_miss, w_bht_upd;
  logic [1:0]              w_ex_ctr, w_ex_ctr_d;
  logic                    w_unused;

  assign w_dec_idx = dec_pc[BHT_IDX_BITS+1:2];
  assign w_ex_idx  = ex_pc[BHT_IDX_BITS+1:2];
  assign w_unused  = ^{ex_pc[ADDR_WIDTH-1:BHT_IDX_BITS+2], ex_pc[1:0]};

  assign w_mem_miss   = mem_is_access & ~d_cache_valid;
  assign w_mispredict = ex_branch_valid & (ex_prediction != ex_outcome);
  assign w_ic_miss    = ~i_cache_valid;
  assign w_load_use   = ex_mem_read & ex_uses_rw & (ex_rw_addr != 5'd0) &
                        ((dec_uses_rs & (dec_rs_addr == ex_rw_addr)) |
                         (dec_uses_rt & (dec_rt_addr == ex_rw_addr)));
  // A branch stuck in EX behind a d-cache miss is trained only once it leaves.
  assign w_bht_upd    = ex_branch_valid & ~w_mem_miss;

  assign dec_prediction          = dec_is_jump | (dec_branch_valid & bht_q[w_dec_idx][1]);
  assign dec_target_post_predict = dec_prediction ? dec_target : dec_pc + ADDR_WIDTH'(4);

  assign w_ex_ctr = bht_q[w_ex_idx];
  always_comb begin
    w_ex_ctr_d = w_ex_ctr;
    if (ex_outcome && w_ex_ctr != 2'b11)
      w_ex_ctr_d = w_ex_ctr + 2'd1;
    else if (!ex_outcome && w_ex_ctr != 2'b00)
      w_ex_ctr_d = w_ex_ctr - 2'd1;
  end

  always_comb begin
    load_pc_we     = 1'b0;
    load_pc_new_pc = '0;
    pc_stall       = 1'b0;
    i2d_stall      = 1'b0;
    i2d_flush      = 1'b0;
    d2e_stall      = 1'b0;
    d2e_flush      = 1'b0;
    e2m_stall      = 1'b0;
    e2m_flush      = 1'b0;
    m2w_stall      = 1'b0;
    m2w_flush      = 1'b0;
    if (!rst_n) begin
      i2d_flush = 1'b1;
      d2e_flush = 1'b1;
      e2m_flush = 1'b1;
      m2w_flush = 1'b1;
    end else if (w_mem_miss) begin
      pc_stall  = 1'b1;
      i2d_stall = 1'b1;
      d2e_stall = 1'b1;
      e2m_stall = 1'b1;
      m2w_flush = 1'b1;
    end else if (w_mispredict) begin
      load_pc_we     = 1'b1;
      load_pc_new_pc = ex_target;
      i2d_flush      = 1'b1;
      d2e_flush      = 1'b1;
    end else if (w_load_use) begin
      pc_stall  = 1'b1;
      i2d_stall = 1'b1;
      d2e_flush = 1'b1;
    end else begin
      if (dec_prediction) begin
        load_pc_we     = 1'b1;
        load_pc_new_pc = dec_target;
        i2d_flush      = 1'b1;
      end
      // A redirect replaces the missing fetch, so the PC must not be held.
      if (w_ic_miss) begin
        i2d_flush = 1'b1;
        pc_stall  = ~dec_prediction;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      stall_cnt_q <= '0;
      br_cnt_q    <= '0;
      mp_cnt_q    <= '0;
    end else begin
      if (w_bht_upd) begin
        bht_q[w_ex_idx] <= w_ex_ctr_d;
        if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_q <= br_cnt_q + 32'd1;
        if (w_mispredict && mp_cnt_q != 32'hFFFF_FFFF) mp_cnt_q <= mp_cnt_q + 32'd1;
      end
      if ((w_mem_miss | w_load_use | w_ic_miss) && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_branches     = br_cnt_q;
  assign perf_mispredicts  = mp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_controller: directed and random checks against a reference model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cache_valid, mem_is_access, d_cache_valid;
  logic [31:0] dec_pc, dec_target, ex_pc, ex_target;
  logic        dec_branch_valid, dec_is_jump, dec_uses_rs, dec_uses_rt;
  logic [4:0]  dec_rs_addr, dec_rt_addr, ex_rw_addr;
  logic        ex_mem_read, ex_uses_rw, ex_branch_valid, ex_prediction, ex_outcome;
  logic        dec_prediction, load_pc_we, pc_stall;
  logic [31:0] dec_target_post_predict, load_pc_new_pc;
  logic        i2d_stall, i2d_flush, d2e_stall, d2e_flush;
  logic        e2m_stall, e2m_flush, m2w_stall, m2w_flush;
  logic [31:0] perf_stall_cycles, perf_branches, perf_mispredicts;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  hazard_controller #(.BHT_IDX_BITS(6), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cache_valid(i_cache_valid), .mem_is_access(mem_is_access), .d_cache_valid(d_cache_valid),
    .dec_pc(dec_pc), .dec_branch_valid(dec_branch_valid), .dec_is_jump(dec_is_jump),
    .dec_target(dec_target), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr),
    .ex_mem_read(ex_mem_read), .ex_uses_rw(ex_uses_rw), .ex_rw_addr(ex_rw_addr),
    .ex_pc(ex_pc), .ex_branch_valid(ex_branch_valid), .ex_prediction(ex_prediction),
    .ex_outcome(ex_outcome), .ex_target(ex_target),
    .dec_prediction(dec_prediction), .dec_target_post_predict(dec_target_post_predict),
    .load_pc_we(load_pc_we), .load_pc_new_pc(load_pc_new_pc), .pc_stall(pc_stall),
    .i2d_stall(i2d_stall), .i2d_flush(i2d_flush), .d2e_stall(d2e_stall), .d2e_flush(d2e_flush),
    .e2m_stall(e2m_stall), .e2m_flush(e2m_flush), .m2w_stall(m2w_stall), .m2w_flush(m2w_flush),
    .perf_stall_cycles(perf_stall_cycles), .perf_branches(perf_branches),
    .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_bht [64];
  longint      m_stall, m_br, m_mp;
  localparam longint c_SAT = 64'h0000_0000_FFFF_FFFF;

  typedef struct packed {
    logic        pred;
    logic [31:0] post;
    logic        we;
    logic [31:0] npc;
    logic        pcs, i2ds, i2df, d2es, d2ef, e2ms, e2mf, m2ws, m2wf;
  } exp_t;

  function automatic bit f_mem_miss();
    return mem_is_access && !d_cache_valid;
  endfunction
  function automatic bit f_mispredict();
    return ex_branch_valid && (ex_prediction != ex_outcome);
  endfunction
  function automatic bit f_load_use();
    bit hit_rs, hit_rt;
    hit_rs = dec_uses_rs && dec_rs_addr == ex_rw_addr;
    hit_rt = dec_uses_rt && dec_rt_addr == ex_rw_addr;
    return ex_mem_read && ex_uses_rw && ex_rw_addr != 0 && (hit_rs || hit_rt);
  endfunction

  function automatic exp_t model();
    exp_t e;
    int   idx;
    e = '0;
    idx = int'(dec_pc[7:2]);
    e.pred = dec_is_jump || (dec_branch_valid && m_bht[idx] >= 2);
    e.post = e.pred ? dec_target : 32'(64'(dec_pc) + 64'd4);
    if (!rst_n) begin
      {e.i2df, e.d2ef, e.e2mf, e.m2wf} = 4'b1111;
    end else if (f_mem_miss()) begin
      {e.pcs, e.i2ds, e.d2es, e.e2ms, e.m2wf} = 5'b11111;
    end else if (f_mispredict()) begin
      e.we = 1; e.npc = ex_target; e.i2df = 1; e.d2ef = 1;
    end else if (f_load_use()) begin
      e.pcs = 1; e.i2ds = 1; e.d2ef = 1;
    end else begin
      if (e.pred) begin e.we = 1; e.npc = dec_target; e.i2df = 1; end
      if (!i_cache_valid) begin e.i2df = 1; e.pcs = !e.we; end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_bht[i] <= 1;
      m_stall <= 0; m_br <= 0; m_mp <= 0;
    end else begin
      if (ex_branch_valid && !f_mem_miss()) begin
        if (ex_outcome) m_bht[int'(ex_pc[7:2])] <= (m_bht[int'(ex_pc[7:2])] + 1 > 3) ? 3 : m_bht[int'(ex_pc[7:2])] + 1;
        else            m_bht[int'(ex_pc[7:2])] <= (m_bht[int'(ex_pc[7:2])] - 1 < 0) ? 0 : m_bht[int'(ex_pc[7:2])] - 1;
        m_br <= (m_br + 1 > c_SAT) ? c_SAT : m_br + 1;
        if (f_mispredict()) m_mp <= (m_mp + 1 > c_SAT) ? c_SAT : m_mp + 1;
      end
      if (f_mem_miss() || f_load_use() || !i_cache_valid)
        m_stall <= (m_stall + 1 > c_SAT) ? c_SAT : m_stall + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = model();
      chk("dec_prediction", 32'(dec_prediction), 32'(e.pred));
      chk("post_predict", dec_target_post_predict, e.post);
      chk("load_pc_we", 32'(load_pc_we), 32'(e.we));
      if (e.we) chk("new_pc", load_pc_new_pc, e.npc);
      chk("stall_flush", {23'd0, pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush,
                          e2m_stall, e2m_flush, m2w_stall, m2w_flush},
          {23'd0, e.pcs, e.i2ds, e.i2df, e.d2es, e.d2ef, e.e2ms, e.e2mf, e.m2ws, e.m2wf});
      chk("perf_stall", perf_stall_cycles, 32'(m_stall));
      chk("perf_br", perf_branches, 32'(m_br));
      chk("perf_mp", perf_mispredicts, 32'(m_mp));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1; i_cache_valid = 1; mem_is_access = 0; d_cache_valid = 1;
    dec_pc = 32'h0040_0000; dec_target = 32'h0; dec_branch_valid = 0; dec_is_jump = 0;
    dec_uses_rs = 0; dec_uses_rt = 0; dec_rs_addr = 0; dec_rt_addr = 0;
    ex_mem_read = 0; ex_uses_rw = 0; ex_rw_addr = 0; ex_pc = 32'h0040_0000;
    ex_branch_valid = 0; ex_prediction = 0; ex_outcome = 0; ex_target = 32'h0;
  endtask

  task automatic ex_branch(input logic [31:0] pc, input logic pred, input logic outc,
                           input logic [31:0] tgt);
    ex_branch_valid = 1; ex_pc = pc; ex_prediction = pred; ex_outcome = outc; ex_target = tgt;
  endtask

  initial begin
    idle();
    rst_n = 0;
    step();
    chk_en = 1;
    #1;
    chk("rst_flushes", {28'd0, i2d_flush, d2e_flush, e2m_flush, m2w_flush}, 32'hF);
    chk("rst_stalls", {28'd0, pc_stall, i2d_stall, d2e_stall, load_pc_we}, 32'h0);

    // Fresh branch predicts not-taken
    step(); idle();
    dec_branch_valid = 1; dec_pc = 32'h0040_0010; dec_target = 32'h0040_0100;
    #2;
    chk("lit_pred0", 32'(dec_prediction), 32'd0);
    chk("lit_post0", dec_target_post_predict, 32'h0040_0014);
    chk("lit_perf0", perf_stall_cycles | perf_branches | perf_mispredicts, 32'd0);

    // Two taken resolutions with not-taken prediction
    for (int k = 0; k < 2; k++) begin
      step(); idle(); ex_branch(32'h0040_0010, 0, 1, 32'h0040_0100);
      #2;
      chk("lit_mp_we", 32'(load_pc_we), 32'd1);
      chk("lit_mp_pc", load_pc_new_pc, 32'h0040_0100);
      chk("lit_mp_fl", {30'd0, i2d_flush, d2e_flush}, 32'd3);
    end
    step(); idle();
    dec_branch_valid = 1; dec_pc = 32'h0040_0010; dec_target = 32'h0040_0100;
    #2;
    chk("lit_mp_cnt", perf_mispredicts, 32'd2);
    chk("lit_pred1", 32'(dec_prediction), 32'd1);
    chk("lit_redir", {31'd0, load_pc_we}, 32'd1);
    chk("lit_redir_pc", load_pc_new_pc, 32'h0040_0100);

    // Load-use on $t0, then clears; then $zero never stalls
    step(); idle();
    ex_mem_read = 1; ex_uses_rw = 1; ex_rw_addr = 5'd8; dec_uses_rt = 1; dec_rt_addr = 5'd8;
    #2;
    chk("lit_lu", {29'd0, pc_stall, i2d_stall, d2e_flush}, 32'd7);
    step(); idle(); dec_uses_rt = 1; dec_rt_addr = 5'd8;
    #2;
    chk("lit_lu_once", {31'd0, pc_stall}, 32'd0);
    step(); idle();
    ex_mem_read = 1; ex_uses_rw = 1; ex_rw_addr = 5'd0; dec_uses_rt = 1; dec_rt_addr = 5'd0;
    #2;
    chk("lit_lu_zero", {31'd0, pc_stall}, 32'd0);

    // Five-cycle d-cache miss with a mispredict waiting in EX
    for (int k = 0; k < 5; k++) begin
      step(); idle(); ex_branch(32'h0040_0020, 0, 1, 32'h0040_0200);
      mem_is_access = 1; d_cache_valid = 0;
      #2;
      chk("lit_miss_st", {27'd0, pc_stall, i2d_stall, d2e_stall, e2m_stall, m2w_flush}, 32'h1F);
      chk("lit_miss_we", {31'd0, load_pc_we}, 32'd0);
    end
    step(); idle(); ex_branch(32'h0040_0020, 0, 1, 32'h0040_0200); mem_is_access = 1;
    #2;
    chk("lit_miss_rd", {31'd0, load_pc_we}, 32'd1);
    chk("lit_miss_pc", load_pc_new_pc, 32'h0040_0200);
    chk("lit_miss_cnt", perf_stall_cycles, 32'd6);
    chk("lit_br_pre", perf_branches, 32'd2);
    step(); idle();
    #2;
    chk("lit_br_once", perf_branches, 32'd3);

    // Jump during i-cache miss
    step(); idle();
    i_cache_valid = 0; dec_branch_valid = 1; dec_is_jump = 1;
    dec_pc = 32'h0040_0040; dec_target = 32'h0040_1000;
    #2;
    chk("lit_jmp", {29'd0, load_pc_we, pc_stall, i2d_flush}, 32'd5);
    chk("lit_jmp_pc", load_pc_new_pc, 32'h0040_1000);

    // Counter saturation at index of 0x0040_0080
    for (int k = 0; k < 3; k++) begin
      step(); idle(); ex_branch(32'h0040_0080, 1, 1, 32'h0040_0300);
    end
    step(); idle(); ex_branch(32'h0040_0080, 1, 0, 32'h0040_0084);
    step(); idle(); dec_branch_valid = 1; dec_pc = 32'h0040_0080; dec_target = 32'h0040_0300;
    #2;
    chk("lit_sat_hi", 32'(dec_prediction), 32'd1);
    step(); idle(); ex_branch(32'h0040_0080, 1, 0, 32'h0040_0084);
    step(); idle(); dec_branch_valid = 1; dec_pc = 32'h0040_0080; dec_target = 32'h0040_0300;
    #2;
    chk("lit_sat_lo", 32'(dec_prediction), 32'd0);
    chk("lit_sat_post", dec_target_post_predict, 32'h0040_0084);

    // Random traffic on a small PC/register set to force collisions
    for (int n = 0; n < 4000; n++) begin
      step();
      rst_n            = ($urandom_range(0, 149) != 0);
      i_cache_valid    = ($urandom_range(0, 4) != 0);
      mem_is_access    = 1'($urandom_range(0, 1));
      d_cache_valid    = ($urandom_range(0, 3) != 0);
      dec_pc           = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC
                                                      : 32'h0040_0000 + 32'($urandom_range(0, 15)) * 4;
      ex_pc            = 32'h0040_0000 + 32'($urandom_range(0, 15)) * 4;
      dec_target       = $urandom;
      ex_target        = $urandom;
      dec_branch_valid = 1'($urandom_range(0, 1));
      dec_is_jump      = dec_branch_valid && ($urandom_range(0, 3) == 0);
      dec_uses_rs      = 1'($urandom_range(0, 1));
      dec_uses_rt      = 1'($urandom_range(0, 1));
      dec_rs_addr      = 5'($urandom_range(0, 3));
      dec_rt_addr      = 5'($urandom_range(0, 3));
      ex_mem_read      = 1'($urandom_range(0, 1));
      ex_uses_rw       = 1'($urandom_range(0, 1));
      ex_rw_addr       = 5'($urandom_range(0, 3));
      ex_branch_valid  = 1'($urandom_range(0, 1));
      ex_prediction    = 1'($urandom_range(0, 1));
      ex_outcome       = 1'($urandom_range(0, 1));
    end

    step();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
